pipeline_mem_arbiter: RTL

Arbitrates one shared single-ported memory between IF-stage instruction fetch and MEM-stage data load/store. Sits between the pipelined CPU and the unified memory. Sequences one outstanding access at a time through a request/ack handshake. Drives pipeline stall signals and bounds fetch starvation and memory hangs.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_mem_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM shared-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_e;

    localparam logic [3:0] SIZE_FETCH = 4'd4;
    localparam logic [3:0] SIZE_DATA  = 4'd8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; clear wins over increment.
module sat_counter #(
    parameter int unsigned Width = 4,
    parameter int unsigned Max   = 15
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != Width'(Max))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store,
// one access at a time, with fetch anti-starvation and an ack timeout.
module pipeline_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 3,
    parameter int unsigned ACK_TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_done,
    output logic [63:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [3:0]  mem_size,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_pipe,
    output logic        err_timeout
);

    localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);
    localparam int unsigned TmoW    = $clog2(ACK_TIMEOUT + 1);

    state_e      state_q, state_d;
    logic        if_done_q, if_done_d, d_done_q, d_done_d;
    logic        err_q, err_d, we_q, we_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [63:0] d_rdata_q, d_rdata_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  size_q, size_d;

    logic [StreakW-1:0] streak;
    logic [TmoW-1:0]    tmo;
    logic busy, if_cand, d_cand, gnt_data, gnt_fetch, timeout_hit;

    assign busy    = (state_q != IDLE);
    // A requester whose done is pulsing is still holding req for the access just served.
    assign if_cand = if_req & ~if_done_q;
    assign d_cand  = d_req & ~d_done_q;

    assign gnt_data    = ~busy & d_cand & ~(if_cand & (streak == StreakW'(MAX_DATA_STREAK)));
    assign gnt_fetch   = ~busy & if_cand & ~gnt_data;
    assign timeout_hit = busy & ~mem_ack & (tmo == TmoW'(ACK_TIMEOUT - 1));

    sat_counter #(
        .Width (StreakW),
        .Max   (MAX_DATA_STREAK)
    ) u_streak (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (gnt_data & if_req),
        .clr_i   (~busy & (gnt_fetch | ~if_req)),
        .count_o (streak)
    );

    sat_counter #(
        .Width (TmoW),
        .Max   (ACK_TIMEOUT)
    ) u_timeout (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (busy & ~mem_ack),
        .clr_i   (~busy),
        .count_o (tmo)
    );

    always_comb begin
        state_d    = state_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_data) begin
                    state_d = DATA;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    size_d  = SIZE_DATA;
                end else if (gnt_fetch) begin
                    state_d = FETCH;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    size_d  = SIZE_FETCH;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata[31:0];
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    if_done_d  = 1'b1;
                    if_rdata_d = '0;
                    err_d      = 1'b1;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    d_done_d = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    d_done_d  = 1'b1;
                    d_rdata_d = '0;
                    err_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            size_q     <= '0;
        end else begin
            state_q    <= state_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
        end
    end

    assign if_done     = if_done_q;
    assign d_done      = d_done_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign err_timeout = err_q;
    assign mem_req     = busy;
    assign mem_we      = (state_q == DATA) & we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_size    = size_q;
    assign stall_pipe  = d_req & ~d_done_q;
    assign stall_if    = (if_req & ~if_done_q) | stall_pipe;

endmodule
